// File: rtl/keypad_pkg.sv
// Shared state codes, idle/reset patterns and index helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef logic [1:0] state_t;

   localparam state_t SCAN     = 2'd0;
   localparam state_t DEBOUNCE = 2'd1;
   localparam state_t PRESSED  = 2'd2;
   localparam state_t RELEASE  = 2'd3;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   function automatic logic [15:0] onehot_of(input logic [1:0] row, input logic [1:0] col);
      onehot_of = 16'h0001 << {row, col};
   endfunction

   function automatic logic single_low(input logic [3:0] v);
      single_low = (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      case (v)
         4'b1101: low_index = 2'd1;
         4'b1011: low_index = 2'd2;
         4'b0111: low_index = 2'd3;
         default: low_index = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix pins plus the decoded key outputs seen by the downstream encoder.
interface keypad_if;

   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] onehot;
   logic        key_valid;
   logic        key_held;

   modport master (input row_n, output col_n, onehot, key_valid, key_held);
   modport slave  (output row_n, input col_n, onehot, key_valid, key_held);

endinterface

// File: rtl/keypad_sync.sv
// 4-bit two-flop synchronizer for the asynchronous row inputs; resets to idle (all 1s).
module keypad_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;
   logic [3:0] stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 4'b1111;
         stable <= 4'b1111;
      end else begin
         meta   <= d;
         stable <= meta;
      end
   end

   assign q = stable;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and a registered one-hot key code.
// Define KEYPAD_REPEAT_EN to re-strobe key_valid every REPEAT_CYC clocks while a key is held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 200000,
   parameter int REPEAT_CYC   = 25000000
) (
   input  logic     clk,
   input  logic     rst_n,
   keypad_if.master bus
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CYC);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [DEB_W-1:0] deb_cnt;
   logic [3:0]       rows;
   logic [3:0]       col_q;
   logic [3:0]       row_cap;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [15:0]      onehot_q;
   logic             valid_q;
   logic             held_q;
   logic             rep_fire;

   keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.row_n),
      .q     (rows)
   );

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYC);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

   logic [REP_W-1:0] rep_cnt;

   // Any state other than PRESSED holds the counter at zero, so entering PRESSED
   // (fresh press or a release bounce) always starts a full repeat interval.
   assign rep_fire = (state == PRESSED) && (rows != ROWS_IDLE) && (rep_cnt == REP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
      end else if (state != PRESSED || rep_fire) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SCAN;
         div_cnt  <= '0;
         deb_cnt  <= '0;
         col_q    <= COL_RESET;
         row_cap  <= ROWS_IDLE;
         row_idx  <= '0;
         col_idx  <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         valid_q <= rep_fire;
         case (state)
            SCAN: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  // Ghosting (several rows low) is treated like no key and scanning moves on.
                  if (single_low(rows)) begin
                     row_cap <= rows;
                     row_idx <= low_index(rows);
                     col_idx <= low_index(col_q);
                     deb_cnt <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     col_q <= {col_q[2:0], col_q[3]};
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (rows != row_cap) begin
                  deb_cnt <= '0;
                  state   <= SCAN;
               end else if (deb_cnt == DEB_LAST) begin
                  onehot_q <= onehot_of(row_idx, col_idx);
                  valid_q  <= 1'b1;
                  held_q   <= 1'b1;
                  deb_cnt  <= '0;
                  state    <= PRESSED;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (rows == ROWS_IDLE) begin
                  deb_cnt <= '0;
                  state   <= RELEASE;
               end
            end
            RELEASE: begin
               if (rows != ROWS_IDLE) begin
                  deb_cnt <= '0;
                  state   <= PRESSED;
               end else if (deb_cnt == DEB_LAST) begin
                  held_q  <= 1'b0;
                  col_q   <= {col_q[2:0], col_q[3]};
                  deb_cnt <= '0;
                  state   <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   assign bus.col_n     = col_q;
   assign bus.onehot    = onehot_q;
   assign bus.key_valid = valid_q;
   assign bus.key_held  = held_q;

endmodule
